// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback
// requesters; the winner is registered for one full cycle and committed writes are counted.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int CNTW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wb_we,
    output logic [4:0]           wb_addr,
    output logic [31:0]          wb_data,
    output logic [CNTW-1:0]      wb_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   next_ptr;
    logic [NREQ-1:0] grant;
    logic            granted;
    logic [4:0]      sel_addr;
    logic [31:0]     sel_data;
    int              idx;

    // Search from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        grant    = '0;
        granted  = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        next_ptr = rr_ptr;
        idx      = 0;
        if (rst_n && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!granted && req_valid[idx]) begin
                    granted    = 1'b1;
                    grant[idx] = 1'b1;
                    sel_addr   = req_addr[5*idx +: 5];
                    sel_data   = req_data[32*idx +: 32];
                    next_ptr   = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
                end
            end
        end
    end

    assign req_ready = grant;

    // A grant to x0 is consumed and advances the pointer but never raises wb_we.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            wb_we    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_count <= '0;
            rr_ptr   <= '0;
        end else if (granted) begin
            wb_addr <= sel_addr;
            wb_data <= sel_data;
            wb_we   <= (sel_addr != 5'd0);
            rr_ptr  <= next_ptr;
            if (sel_addr != 5'd0) wb_count <= wb_count + CNTW'(1);
        end else begin
            wb_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus pushes expected writes into a
// scoreboard queue and a falling-edge monitor pops and compares each presented write.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [36:0] exp_q[$];
    logic [31:0] rf[32];

    regfile_wb_arbiter #(.NREQ(3), .CNTW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_count  (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-file model: x0 hardwired to zero, writes on the falling edge.
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(negedge clk) if (wb_we && wb_addr != 5'd0) rf[wb_addr] <= wb_data;

    // Monitor: every presented write must match the oldest expected one.
    always @(negedge clk) begin
        if (wb_we) begin
            if (exp_q.size() == 0) begin
                check("spurious_wb_we", 64'(wb_we), 64'(0));
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wb_addr", 64'(wb_addr), 64'(e[36:32]));
                check("wb_data", 64'(wb_data), 64'(e[31:0]));
            end
        end
    end

    // One cycle of stimulus; exp_ready is the hand-computed grant for this cycle.
    task automatic step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                        input logic h, input logic [2:0] exp_ready);
        @(negedge clk);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        hold      = h;
        #1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        for (int i = 0; i < 3; i++)
            if (exp_ready[i] && a[5*i +: 5] != 5'd0)
                exp_q.push_back({a[5*i +: 5], d[32*i +: 32]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, '0, '0, 1'b0, 3'b000);
    endtask

    initial begin
        rst_n     = 1'b0;
        hold      = 1'b0;
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = '0;

        // Reset: ready forced low even with every requester valid.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("reset_ready", 64'(req_ready), 64'(0));
            check("reset_we", 64'(wb_we), 64'(0));
            check("reset_count", 64'(wb_count), 64'(0));
        end
        req_valid = 3'b000;
        rst_n     = 1'b1;
        idle(5);
        check("idle_count", 64'(wb_count), 64'(0));
        check("idle_we", 64'(wb_we), 64'(0));

        // Single write from requester 0.
        step(3'b001, {5'd0, 5'd0, 5'd5}, {64'h0, 32'hDEAD_BEEF}, 1'b0, 3'b001);
        idle(1);
        check("single_count", 64'(wb_count), 64'(1));
        check("rf_x5", 64'(rf[5]), 64'h0000_0000_DEAD_BEEF);

        // x0 from requester 1 is accepted but discarded (rr_ptr 1 -> 2).
        step(3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234_5678, 32'h0}, 1'b0, 3'b010);
        idle(1);
        check("x0_count", 64'(wb_count), 64'(1));
        check("rf_x0", 64'(rf[0]), 64'(0));

        // Requester 2 brings rr_ptr back to 0.
        step(3'b100, {5'd9, 5'd0, 5'd0}, {32'hCAFE_F00D, 64'h0}, 1'b0, 3'b100);
        idle(1);
        check("r2_count", 64'(wb_count), 64'(2));

        // Round-robin 0,1,2 with each dropping valid after its handshake.
        step(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b0, 3'b001);
        step(3'b110, {5'd3, 5'd2, 5'd1}, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b0, 3'b010);
        step(3'b100, {5'd3, 5'd2, 5'd1}, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b0, 3'b100);
        idle(1);
        check("rr_count", 64'(wb_count), 64'(5));

        // Contention 0 vs 2 on the same register: alternates, last grant (2) wins.
        for (int i = 0; i < 3; i++) begin
            step(3'b101, {5'd10, 5'd0, 5'd10}, {32'hBBBB_2222, 32'h0, 32'hAAAA_0000}, 1'b0, 3'b001);
            step(3'b101, {5'd10, 5'd0, 5'd10}, {32'hBBBB_2222, 32'h0, 32'hAAAA_0000}, 1'b0, 3'b100);
        end

        // Hold with requester 1 pending, then serviced once hold falls.
        for (int i = 0; i < 4; i++)
            step(3'b010, {5'd0, 5'd12, 5'd0}, {32'h0, 32'hC0DE_0012, 32'h0}, 1'b1, 3'b000);
        check("contend_count", 64'(wb_count), 64'(11));
        check("rf_x10", 64'(rf[10]), 64'h0000_0000_BBBB_2222);
        check("hold_we", 64'(wb_we), 64'(0));
        step(3'b010, {5'd0, 5'd12, 5'd0}, {32'h0, 32'hC0DE_0012, 32'h0}, 1'b0, 3'b010);

        // Async reset while the x12 write is held: it must be dropped.
        @(posedge clk);
        #2;
        check("pre_reset_we", 64'(wb_we), 64'(1));
        rst_n     = 1'b0;
        req_valid = 3'b000;
        #1;
        check("async_we", 64'(wb_we), 64'(0));
        check("async_count", 64'(wb_count), 64'(0));
        check("async_ready", 64'(req_ready), 64'(0));
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        #1;
        check("rf_x12_dropped", 64'(rf[12]), 64'(0));
        rst_n = 1'b1;

        // After reset rr_ptr is 0 again: requester 0 wins.
        step(3'b111, {5'd15, 5'd14, 5'd13}, {32'h0F0F_0F0F, 32'h0E0E_0E0E, 32'h0D0D_0D0D}, 1'b0, 3'b001);
        idle(2);
        check("post_reset_count", 64'(wb_count), 64'(1));
        check("rf_x13", 64'(rf[13]), 64'h0000_0000_0D0D_0D0D);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between NREQ writeback requesters, e.g. ALU, load unit and mul/div.
- Round-robin arbitration with a valid/ready handshake per requester.
- The winning request is registered on the rising edge and held for one full cycle, so the register file's falling-edge write samples stable values.
- Writes to x0 are accepted and discarded, and the block counts committed writes for debug.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- CNTW, 32, width of committed-write counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  freeze: no grants while high.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  5*NREQ  destination register; requester i uses bits [5i+4:5i].
- req_data  in  32*NREQ  write data; requester i uses bits [32i+31:32i].
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] && req_ready[i] at a rising edge.
- wb_we  out  1  drives regfile we3.
- wb_addr  out  5  drives regfile wa3.
- wb_data  out  32  drives regfile wd3.
- wb_count  out  CNTW  number of committed non-x0 writes.

Behaviour:
- Reset (rst_n=0, takes effect immediately): wb_we=0, wb_addr=0, wb_data=0, wb_count=0, rr_ptr=0. req_ready is forced to 0 while rst_n=0.
- Reset mid-operation: a latched, uncommitted write is dropped and wb_we falls asynchronously.
- Priority state rr_ptr, range 0..NREQ-1, names the highest-priority requester.
- Search order: rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
- req_ready is combinational.
  - It is one-hot on the first valid requester in search order.
  - It is all-zero if hold=1, rst_n=0, or no requester is valid.
- req_ready never asserts for a requester whose req_valid is 0.
- Handshake: a requester must hold req_valid, req_addr and req_data stable until its req_ready is seen high at a rising edge.
- Rising edge with grant to i:
  - wb_addr <= addr_i and wb_data <= data_i.
  - wb_we <= (addr_i != 0).
  - rr_ptr <= (i+1) mod NREQ.
  - wb_count <= wb_count + (addr_i != 0), wrapping at 2^CNTW.
- Rising edge without grant:
  - wb_we <= 0.
  - wb_addr, wb_data and rr_ptr hold.
- Latency:
  - Handshake at rising edge k: wb_we is high from edge k to edge k+1, and the register file commits at the falling edge in between.
  - Throughput is one write per cycle.
- x0: the request is accepted (req_ready=1, rr_ptr advances) but wb_we stays 0 and wb_count does not increment.
- Two requesters targeting the same register in consecutive cycles: both commit in grant order, and the later one wins.
- hold=1 for N cycles:
  - No handshakes.
  - wb_we=0 from the first rising edge after hold rises.
  - rr_ptr unchanged.
  - Pending requests stay valid and are serviced after hold falls, in round-robin order.
- A single requester that is continuously valid is granted every cycle.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NREQ-1,0,...; no requester waits more than NREQ-1 grants.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then all req_valid=0 for 5 cycles -> wb_we=0, req_ready=0, wb_count=0 throughout.
- Single write: req0 addr=5, data=0xDEADBEEF for one handshake -> req_ready=3'b001 that cycle; next cycle wb_we=1, wb_addr=5, wb_data=0xDEADBEEF; wb_count=1; the regfile reads x5=0xDEADBEEF afterwards.
- Round-robin: all three valid with addrs 1, 2, 3, each dropping valid after its handshake -> grants in order 0,1,2 on consecutive edges; wb_addr sequence 1,2,3; rr_ptr ends at 0.
- Continuous contention: req0 and req2 always valid for 6 cycles, rr_ptr=0 -> grants alternate 0,2,0,2,0,2; wb_count=6.
- x0 discard: req1 addr=0, data=0x12345678 -> req_ready[1]=1, wb_we stays 0, wb_count unchanged, x0 still reads 0.
- Hold and async reset:
  - hold=1 for 4 cycles with req1 valid -> no req_ready and wb_we=0; req1 is granted on the first edge after hold falls.
  - Pulsing rst_n low mid-cycle while wb_we=1 -> wb_we drops immediately and the dropped write is not committed.
